// File: rtl/ch_mem_pkg.sv
// Shared definitions for the ch_mem loader and layer scheduler: state
// encoding, default geometry and counter width helpers.
package ch_mem_pkg;

    localparam int QUAN_SIZE_DEF         = 4;
    localparam int CHECK_PARALLELISM_DEF = 85;
    localparam int ROW_CHUNK_NUM_DEF     = 9;
    localparam int LAYER_NUM_DEF         = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_DECODE = 2'd2
    } ld_state_e;

    // Number of chunk slots held by one ch_mem lane.
    function automatic int depth_of(input int row_chunks, input int layers);
        return row_chunks * layers;
    endfunction

    // Bits needed to index n positions; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ch_pos_counter.sv
// Chunk/layer rotation position counter. Chunk wraps into layer, layer
// wraps to zero, so the pair walks all ROW_CHUNK_NUM*LAYER_NUM slots.
module ch_pos_counter
    import ch_mem_pkg::*;
#(
    parameter int ROW_CHUNK_NUM = ROW_CHUNK_NUM_DEF,
    parameter int LAYER_NUM     = LAYER_NUM_DEF,
    localparam int CHUNK_W      = cnt_width(ROW_CHUNK_NUM),
    localparam int LAYER_W      = cnt_width(LAYER_NUM)
) (
    input  logic               sys_clk,
    input  logic               rstn,
    input  logic               clr_i,
    input  logic               en_i,
    output logic [CHUNK_W-1:0] chunk_idx_o,
    output logic [LAYER_W-1:0] layer_idx_o
);

    logic [CHUNK_W-1:0] chunk_q, chunk_d;
    logic [LAYER_W-1:0] layer_q, layer_d;

    // Next position: clear wins over advance; chunk wrap carries into layer.
    always_comb begin
        chunk_d = chunk_q;
        layer_d = layer_q;
        if (clr_i) begin
            chunk_d = '0;
            layer_d = '0;
        end else if (en_i) begin
            if (chunk_q == CHUNK_W'(ROW_CHUNK_NUM - 1)) begin
                chunk_d = '0;
                if (layer_q == LAYER_W'(LAYER_NUM - 1)) begin
                    layer_d = '0;
                end else begin
                    layer_d = layer_q + LAYER_W'(1);
                end
            end else begin
                chunk_d = chunk_q + CHUNK_W'(1);
                layer_d = layer_q;
            end
        end else begin
            chunk_d = chunk_q;
            layer_d = layer_q;
        end
    end

    // Position registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            chunk_q <= '0;
            layer_q <= '0;
        end else begin
            chunk_q <= chunk_d;
            layer_q <= layer_d;
        end
    end

    assign chunk_idx_o = chunk_q;
    assign layer_idx_o = layer_q;

endmodule

// File: rtl/ch_msg_loader.sv
// Channel message loader: streams DEPTH row chunks into the ch_mem lane
// array, then turns decoder shift requests into ch_en pulses while
// tracking the rotation position for the layer scheduler.
module ch_msg_loader
    import ch_mem_pkg::*;
#(
    parameter int QUAN_SIZE         = QUAN_SIZE_DEF,
    parameter int CHECK_PARALLELISM = CHECK_PARALLELISM_DEF,
    parameter int ROW_CHUNK_NUM     = ROW_CHUNK_NUM_DEF,
    parameter int LAYER_NUM         = LAYER_NUM_DEF,
    localparam int BUS_W            = CHECK_PARALLELISM * QUAN_SIZE,
    localparam int CHUNK_W          = cnt_width(ROW_CHUNK_NUM),
    localparam int LAYER_W          = cnt_width(LAYER_NUM)
) (
    input  logic               sys_clk,
    input  logic               rstn,
    input  logic               frame_start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BUS_W-1:0]   in_data,
    input  logic               dec_shift_req,
    output logic [BUS_W-1:0]   ch_msg_bus,
    output logic               v2c_src,
    output logic               ch_en,
    output logic               load_done,
    output logic               busy,
    output logic [CHUNK_W-1:0] chunk_idx,
    output logic [LAYER_W-1:0] layer_idx
);

    localparam int DEPTH  = depth_of(ROW_CHUNK_NUM, LAYER_NUM);
    localparam int LOAD_W = cnt_width(DEPTH + 1);

    ld_state_e          state_q, state_d;
    logic [LOAD_W-1:0]  load_cnt_q, load_cnt_d;
    logic [BUS_W-1:0]   bus_q;
    logic               v2c_q, en_q, done_q;

    logic               accept_s;
    logic               last_s;
    logic               shift_s;
    logic               pos_clr_s;

    // Next state, beat acceptance and shift issue; frame_start overrides
    // any same-cycle beat or shift request.
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        accept_s   = 1'b0;
        last_s     = 1'b0;
        shift_s    = 1'b0;
        pos_clr_s  = frame_start;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d    = ST_LOAD;
                    load_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (frame_start) begin
                    state_d    = ST_LOAD;
                    load_cnt_d = '0;
                end else if (in_valid) begin
                    accept_s   = 1'b1;
                    load_cnt_d = load_cnt_q + LOAD_W'(1);
                    if (load_cnt_q == LOAD_W'(DEPTH - 1)) begin
                        state_d = ST_DECODE;
                        last_s  = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DECODE: begin
                if (frame_start) begin
                    state_d    = ST_LOAD;
                    load_cnt_d = '0;
                end else begin
                    state_d = ST_DECODE;
                    shift_s = dec_shift_req;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                load_cnt_d = '0;
            end
        endcase
    end

    // State and load counter registers.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            load_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
        end
    end

    // Registered drive of the ch_mem bus and strobes, one cycle after the
    // accept or request; the bus holds its last beat between accepts.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            bus_q  <= '0;
            v2c_q  <= 1'b0;
            en_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            bus_q  <= accept_s ? in_data : bus_q;
            v2c_q  <= accept_s;
            en_q   <= accept_s | shift_s;
            done_q <= last_s;
        end
    end

    ch_pos_counter #(
        .ROW_CHUNK_NUM (ROW_CHUNK_NUM),
        .LAYER_NUM     (LAYER_NUM)
    ) u_pos (
        .sys_clk     (sys_clk),
        .rstn        (rstn),
        .clr_i       (pos_clr_s),
        .en_i        (shift_s),
        .chunk_idx_o (chunk_idx),
        .layer_idx_o (layer_idx)
    );

    assign in_ready   = (state_q == ST_LOAD);
    assign busy       = (state_q != ST_IDLE);
    assign ch_msg_bus = bus_q;
    assign v2c_src    = v2c_q;
    assign ch_en      = en_q;
    assign load_done  = done_q;

endmodule
